// File: rtl/carregador_programa_hd_pkg.sv
// Shared constants and FSM encoding for the HD-to-instruction-memory program loader.
package carregador_programa_hd_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 9;
    localparam int TRILHA_W_DEF = 4;
    localparam int SETOR_W_DEF  = 6;
    localparam int PROC_W_DEF   = 3;
    localparam int TAM_PART_DEF = 50;
    localparam int NUM_PROC_DEF = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        ENDER   = 3'd2,
        ESPERA  = 3'd3,
        ESCREVE = 3'd4,
        FIM     = 3'd5,
        ERRO    = 3'd6
    } estado_t;

endpackage

// File: rtl/carregador_programa_hd_calc_base_particao.sv
// Partition base address: id_proc * TAM_PART, evaluated in ADDR_W bits.
module calc_base_particao #(
    parameter int PROC_W   = 3,
    parameter int ADDR_W   = 9,
    parameter int TAM_PART = 50
) (
    input  logic [PROC_W-1:0] id_proc,
    output logic [ADDR_W-1:0] base
);

    assign base = ADDR_W'(id_proc) * ADDR_W'(TAM_PART);

endmodule

// File: rtl/carregador_programa_hd.sv
// Copies n_words consecutive HD sectors of one track into a process partition of instruction memory.
// Optional CARREGADOR_CHECKSUM_EN adds an XOR checksum output of the words written.
module carregador_programa_hd
    import carregador_programa_hd_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int TRILHA_W = TRILHA_W_DEF,
    parameter int SETOR_W  = SETOR_W_DEF,
    parameter int PROC_W   = PROC_W_DEF,
    parameter int TAM_PART = TAM_PART_DEF,
    parameter int NUM_PROC = NUM_PROC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [TRILHA_W-1:0] trilha,
    input  logic [SETOR_W-1:0]  n_words,
    input  logic [PROC_W-1:0]   id_proc,
    output logic [TRILHA_W-1:0] hd_trilha,
    output logic [SETOR_W-1:0]  hd_setor,
    input  logic [DATA_W-1:0]   hd_dado,
    output logic [ADDR_W-1:0]   mi_ender,
    output logic [DATA_W-1:0]   mi_dado,
    output logic                mi_we,
    output logic                busy,
    output logic                done,
    output logic                erro
`ifdef CARREGADOR_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum
`endif
);

    estado_t               estado, estado_prox;
    logic [TRILHA_W-1:0]   trilha_q;
    logic [SETOR_W-1:0]    n_words_q;
    logic [PROC_W-1:0]     id_proc_q;
    logic [SETOR_W-1:0]    idx, idx_prox;
    logic [ADDR_W-1:0]     base;
    logic                  aceita;
    logic                  invalido;
    logic                  ultimo;

    calc_base_particao #(
        .PROC_W   (PROC_W),
        .ADDR_W   (ADDR_W),
        .TAM_PART (TAM_PART)
    ) u_calc_base (
        .id_proc (id_proc_q),
        .base    (base)
    );

    assign aceita   = (estado == IDLE) && start;
    assign invalido = (n_words_q == '0) || (n_words_q > SETOR_W'(TAM_PART))
                   || (id_proc_q >= PROC_W'(NUM_PROC));
    assign ultimo   = (SETOR_W'(idx + 1'b1) == n_words_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        estado_prox = estado;
        idx_prox    = idx;
        case (estado)
            IDLE:    if (start) begin
                         estado_prox = CHECK;
                         idx_prox    = '0;
                     end
            CHECK:   estado_prox = invalido ? ERRO : ENDER;
            ENDER:   estado_prox = ESPERA;
            ESPERA:  estado_prox = ESCREVE;
            ESCREVE: begin
                         estado_prox = ultimo ? FIM : ENDER;
                         idx_prox    = SETOR_W'(idx + 1'b1);
                     end
            FIM:     estado_prox = IDLE;
            ERRO:    estado_prox = IDLE;
            default: estado_prox = IDLE;
        endcase
    end

    // Write port is a pure decode of ESCREVE so a reset drops mi_we on the very next edge.
    assign mi_we    = (estado == ESCREVE);
    assign mi_ender = mi_we ? (base + ADDR_W'(idx)) : '0;
    assign mi_dado  = mi_we ? hd_dado : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= IDLE;
            trilha_q  <= '0;
            n_words_q <= '0;
            id_proc_q <= '0;
            idx       <= '0;
            hd_trilha <= '0;
            hd_setor  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            erro      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            estado <= estado_prox;
            idx    <= idx_prox;
            done   <= (estado == FIM);
            erro   <= (estado == ERRO);
            if (aceita) begin
                trilha_q  <= trilha;
                n_words_q <= n_words;
                id_proc_q <= id_proc;
                busy      <= 1'b1;
            end
            if (estado == FIM || estado == ERRO)
                busy <= 1'b0;
            // HD address is loaded entering ENDER and held through ESPERA for the read latency.
            if (estado_prox == ENDER) begin
                hd_trilha <= trilha_q;
                hd_setor  <= idx_prox;
            end
        end
    end

`ifdef CARREGADOR_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)
            checksum <= '0;
        else if (aceita)
            checksum <= '0;
        else if (estado == ESCREVE)
            checksum <= checksum ^ hd_dado;
    end
`endif

endmodule
